// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control unit: sequences IF/ID/EXE/MEM/WB with a bounded data-memory wait.
// Define ILLEGAL_TRAP_EN to send undefined opcodes to TRAP instead of executing them as NOPs.
module mc_control_fsm #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic               zero,
  input  logic               sign,
  input  logic               mem_ready,
  output logic [3:0]         State,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               DBDataSrc,
  output logic               nRD,
  output logic               nWR,
  output logic [1:0]         RegDst,
  output logic               ExtSel,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               halted,
  output logic               trap,
  output logic               mem_err
);

  localparam logic [5:0] OP_ADD  = 6'b000000, OP_SUB  = 6'b000001, OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000, OP_AND  = 6'b010001, OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000, OP_SLT  = 6'b100110, OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000, OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100, OP_BNE  = 6'b110101, OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000, OP_JR   = 6'b111001, OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [TO_W-1:0] CNT_ONE = TO_W'(1);
  localparam logic [TO_W-1:0] CNT_MAX = TO_W'(MEM_TIMEOUT);

`ifdef ILLEGAL_TRAP_EN
  localparam bit ILL_TRAP_C = 1'b1;
`else
  localparam bit ILL_TRAP_C = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IF     = 4'd0, S_ID  = 4'd1, S_EXE_AL = 4'd2, S_WB_AL = 4'd3, S_EXE_BR = 4'd4,
    S_EXE_LS = 4'd5, S_MEM = 4'd6, S_WB_LD  = 4'd7, S_HALT  = 4'd8, S_TRAP   = 4'd9
  } state_t;

  state_t          state_r, next_s;
  logic [TO_W-1:0] wait_cnt_r;
  logic            mem_err_r;
  logic            timeout_s;
  logic [2:0]      alu3_s;

  function automatic logic is_rtype(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

  function automatic logic is_al(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ORI, OP_SLTI: return 1'b1;
      default:                  return is_rtype(op);
    endcase
  endfunction

  function automatic logic is_br(input logic [5:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLTZ: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_ls(input logic [5:0] op);
    return (op == OP_SW) || (op == OP_LW);
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_J, OP_JR, OP_JAL, OP_HALT: return 1'b1;
      default:                      return is_al(op) || is_br(op) || is_ls(op);
    endcase
  endfunction

  function automatic logic uses_imm(input logic [5:0] op);
    case (op)
      OP_ADDI, OP_ORI, OP_SLTI, OP_LW, OP_SW: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] alu_op(input logic [5:0] op);
    case (op)
      OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: return 3'b001;
      OP_SLL:                          return 3'b100;
      OP_OR, OP_ORI:                   return 3'b101;
      OP_AND:                          return 3'b110;
      OP_SLT, OP_SLTI:                 return 3'b111;
      default:                         return 3'b000;
    endcase
  endfunction

  function automatic logic br_taken(input logic [5:0] op, input logic z, input logic s);
    case (op)
      OP_BEQ:  return z;
      OP_BNE:  return !z;
      OP_BLTZ: return s;
      default: return 1'b0;
    endcase
  endfunction

  // mem_ready arriving on the last allowed cycle still wins over the timeout
  assign timeout_s = (state_r == S_MEM) && !mem_ready && (wait_cnt_r == CNT_MAX);
  assign State     = state_r;
  assign mem_err   = mem_err_r;

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state_r <= S_IF;
    else       state_r <= next_s;
  end

  // MEM wait counter and sticky timeout flag
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wait_cnt_r <= {TO_W{1'b0}};
      mem_err_r  <= 1'b0;
    end else begin
      if (state_r == S_EXE_LS)
        wait_cnt_r <= {TO_W{1'b0}};
      else if ((state_r == S_MEM) && !mem_ready && (wait_cnt_r != CNT_MAX))
        wait_cnt_r <= wait_cnt_r + CNT_ONE;
      else
        wait_cnt_r <= wait_cnt_r;
      mem_err_r <= mem_err_r | timeout_s;
    end
  end

  // Next-state decode
  always_comb begin
    next_s = S_IF;
    case (state_r)
      S_IF: next_s = S_ID;
      S_ID: begin
        if (is_al(Opcode))              next_s = S_EXE_AL;
        else if (is_br(Opcode))         next_s = S_EXE_BR;
        else if (is_ls(Opcode))         next_s = S_EXE_LS;
        else if (Opcode == OP_HALT)     next_s = S_HALT;
        else if (is_legal(Opcode))      next_s = S_IF;
        else                            next_s = ILL_TRAP_C ? S_TRAP : S_IF;
      end
      S_EXE_AL: next_s = S_WB_AL;
      S_WB_AL:  next_s = S_IF;
      S_EXE_BR: next_s = S_IF;
      S_EXE_LS: next_s = S_MEM;
      S_MEM: begin
        if (mem_ready)      next_s = (Opcode == OP_LW) ? S_WB_LD : S_IF;
        else if (timeout_s) next_s = S_TRAP;
        else                next_s = S_MEM;
      end
      S_WB_LD: next_s = S_IF;
      S_HALT:  next_s = S_HALT;
      S_TRAP:  next_s = S_TRAP;
      default: next_s = S_IF;
    endcase
  end

  // Datapath control decode; everything held inactive while Reset is high
  always_comb begin
    PCWre = 1'b0; IRWre = 1'b0; RegWre = 1'b0; ALUSrcA = 1'b0; ALUSrcB = 1'b0;
    DBDataSrc = 1'b0; nRD = 1'b1; nWR = 1'b1; RegDst = 2'b00; ExtSel = 1'b0;
    PCSrc = 2'b00; alu3_s = 3'b000; halted = 1'b0; trap = 1'b0;
    if (Reset) begin
      IRWre = 1'b0;
    end else begin
      if ((state_r == S_EXE_AL) || (state_r == S_EXE_BR) || (state_r == S_EXE_LS)) begin
        ALUSrcA = (Opcode == OP_SLL);
        ALUSrcB = uses_imm(Opcode);
        ExtSel  = (Opcode != OP_ORI);
        alu3_s  = alu_op(Opcode);
      end else begin
        alu3_s  = 3'b000;
      end
      case (state_r)
        S_IF: IRWre = 1'b1;
        S_ID: begin
          case (Opcode)
            OP_J:    begin PCWre = 1'b1; PCSrc = 2'b11; end
            OP_JR:   begin PCWre = 1'b1; PCSrc = 2'b10; end
            OP_JAL:  begin PCWre = 1'b1; PCSrc = 2'b11; RegWre = 1'b1; RegDst = 2'b00; end
            default: PCWre = !is_legal(Opcode) && !ILL_TRAP_C;
          endcase
        end
        S_EXE_BR: begin
          PCWre = 1'b1;
          PCSrc = br_taken(Opcode, zero, sign) ? 2'b01 : 2'b00;
        end
        S_WB_AL: begin
          RegWre = 1'b1;
          PCWre  = 1'b1;
          RegDst = is_rtype(Opcode) ? 2'b10 : 2'b01;
        end
        S_MEM: begin
          nRD   = (Opcode != OP_LW);
          nWR   = (Opcode != OP_SW);
          PCWre = (Opcode == OP_SW) && mem_ready;
        end
        S_WB_LD: begin
          RegWre    = 1'b1;
          DBDataSrc = 1'b1;
          RegDst    = 2'b01;
          PCWre     = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        S_TRAP:  trap   = 1'b1;
        default: IRWre  = 1'b0;
      endcase
    end
    ALUOp      = {ALUOP_W{1'b0}};
    ALUOp[2:0] = alu3_s;
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: per-instruction expected traces against random stimulus.
module tb_mc_control_fsm;
  localparam int ALUOP_W = 3, MEM_TIMEOUT = 15, TO_W = 4;

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR_ = 6'b010000;
  localparam logic [5:0] AND_ = 6'b010001, ORI = 6'b010010, SLL = 6'b011000, SLT = 6'b100110;
  localparam logic [5:0] SLTI = 6'b100111, SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100;
  localparam logic [5:0] BNE = 6'b110101, BLTZ = 6'b110110, J = 6'b111000, JR = 6'b111001;
  localparam logic [5:0] JAL = 6'b111010, HLT = 6'b111111, ILL = 6'b101010;

  logic CLK = 1'b0, Reset = 1'b1;
  logic [5:0] Opcode = 6'b000000;
  logic zero = 1'b0, sign = 1'b0, mem_ready = 1'b0;
  logic [3:0] State;
  logic PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, DBDataSrc, nRD, nWR, ExtSel, halted, trap, mem_err;
  logic [1:0] RegDst, PCSrc;
  logic [ALUOP_W-1:0] ALUOp;

  int total = 0, bad = 0;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, rgw, sa, sb, db, nrd, nwr;
    logic [1:0] rd;
    logic ext;
    logic [1:0] ps;
    logic [2:0] aop;
    logic h, t, me;
  } vec_t;

  vec_t exp_q[$];
  logic rdy_q[$];
  logic me_m = 1'b0;
  logic [5:0] legal [17] = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTI, SW, LW, BEQ, BNE, BLTZ, J, JR, JAL};

  mc_control_fsm #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .zero(zero), .sign(sign), .mem_ready(mem_ready),
    .State(State), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .DBDataSrc(DBDataSrc), .nRD(nRD), .nWR(nWR), .RegDst(RegDst),
    .ExtSel(ExtSel), .PCSrc(PCSrc), .ALUOp(ALUOp), .halted(halted), .trap(trap), .mem_err(mem_err)
  );

  always #5 CLK = ~CLK;

  function automatic vec_t cap();
    vec_t o;
    o.st = State; o.pcw = PCWre; o.irw = IRWre; o.rgw = RegWre; o.sa = ALUSrcA; o.sb = ALUSrcB;
    o.db = DBDataSrc; o.nrd = nRD; o.nwr = nWR; o.rd = RegDst; o.ext = ExtSel; o.ps = PCSrc;
    o.aop = ALUOp[2:0]; o.h = halted; o.t = trap; o.me = mem_err;
    return o;
  endfunction

  function automatic vec_t idle(input int st);
    vec_t v = '0;
    v.st = st[3:0]; v.nrd = 1'b1; v.nwr = 1'b1; v.me = me_m;
    return v;
  endfunction

  function automatic logic [2:0] ref_aluop(input logic [5:0] op);
    if (op == SUB || op == BEQ || op == BNE || op == BLTZ) return 3'b001;
    else if (op == SLL) return 3'b100;
    else if (op == OR_ || op == ORI) return 3'b101;
    else if (op == AND_) return 3'b110;
    else if (op == SLT || op == SLTI) return 3'b111;
    else return 3'b000;
  endfunction

  function automatic void push(input vec_t v, input logic r);
    exp_q.push_back(v);
    rdy_q.push_back(r);
  endfunction

  // Expected per-cycle trace of one instruction starting in IF; waits = mem_ready-low cycles in MEM.
  function automatic void model(input logic [5:0] op, input logic z, input logic s, input int waits);
    vec_t v;
    logic rtype = (op == ADD || op == SUB || op == OR_ || op == AND_ || op == SLL || op == SLT);
    logic itype = (op == ADDI || op == ORI || op == SLTI);
    v = idle(0); v.irw = 1'b1; push(v, 1'($urandom));
    v = idle(1);
    if (op == J || op == JR || op == JAL) begin
      v.pcw = 1'b1;
      v.ps = (op == JR) ? 2'b10 : 2'b11;
      v.rgw = (op == JAL);
      push(v, 1'($urandom));
    end else if (op == HLT) begin
      push(v, 1'($urandom));
      for (int i = 0; i < 20; i++) begin v = idle(8); v.h = 1'b1; push(v, 1'($urandom)); end
    end else if (rtype || itype) begin
      push(v, 1'($urandom));
      v = idle(2); v.aop = ref_aluop(op); v.sa = (op == SLL); v.sb = itype; v.ext = (op != ORI);
      push(v, 1'($urandom));
      v = idle(3); v.rgw = 1'b1; v.pcw = 1'b1; v.rd = rtype ? 2'b10 : 2'b01;
      push(v, 1'($urandom));
    end else if (op == BEQ || op == BNE || op == BLTZ) begin
      push(v, 1'($urandom));
      v = idle(4); v.aop = 3'b001; v.ext = 1'b1; v.pcw = 1'b1;
      v.ps = ((op == BEQ && z) || (op == BNE && !z) || (op == BLTZ && s)) ? 2'b01 : 2'b00;
      push(v, 1'($urandom));
    end else if (op == LW || op == SW) begin
      push(v, 1'($urandom));
      v = idle(5); v.sb = 1'b1; v.ext = 1'b1; push(v, 1'($urandom));
      for (int k = 0; k < ((waits > MEM_TIMEOUT) ? MEM_TIMEOUT + 1 : waits); k++) begin
        v = idle(6); v.nrd = (op != LW); v.nwr = (op != SW); push(v, 1'b0);
      end
      if (waits > MEM_TIMEOUT) begin
        me_m = 1'b1;
        for (int i = 0; i < 5; i++) begin v = idle(9); v.t = 1'b1; push(v, 1'($urandom)); end
      end else begin
        v = idle(6); v.nrd = (op != LW); v.nwr = (op != SW); v.pcw = (op == SW); push(v, 1'b1);
        if (op == LW) begin
          v = idle(7); v.rgw = 1'b1; v.db = 1'b1; v.rd = 2'b01; v.pcw = 1'b1; push(v, 1'($urandom));
        end
      end
    end else begin
`ifdef ILLEGAL_TRAP_EN
      push(v, 1'($urandom));
      for (int i = 0; i < 5; i++) begin v = idle(9); v.t = 1'b1; push(v, 1'($urandom)); end
`else
      v.pcw = 1'b1;
      push(v, 1'($urandom));
`endif
    end
  endfunction

  task automatic do_reset();
    Reset = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    me_m = 1'b0;
  endtask

  task automatic test_reset();
    vec_t o, e;
    Opcode = JAL; mem_ready = 1'b1;
    @(negedge CLK); @(negedge CLK);
    o = cap(); e = idle(0); total++;
    if (o !== e) begin bad++; $display("FAIL reset got=%h exp=%h", o, e); end
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  task automatic test_add();
    vec_t o, e;
    Opcode = ADD; model(ADD, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge CLK); o = cap(); total++;
      if (o !== e) begin bad++; $display("FAIL add st=%0d got=%h exp=%h", e.st, o, e); end
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_branch();
    vec_t o, e;
    logic [5:0] ops [4] = '{BEQ, BEQ, BNE, BLTZ};
    for (int n = 0; n < 8; n++) begin
      Opcode = ops[n % 4];
      zero = (n < 2) ? ~1'(n) : 1'($urandom);
      sign = 1'($urandom);
      model(Opcode, zero, sign, 0);
      while (exp_q.size() > 0) begin
        mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
        @(negedge CLK); o = cap(); total++;
        if (o !== e) begin bad++; $display("FAIL branch op=%b z=%b s=%b got=%h exp=%h", Opcode, zero, sign, o, e); end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_mem_wait();
    vec_t o, e;
    logic [5:0] ops [3] = '{LW, SW, LW};
    int ws [3] = '{3, MEM_TIMEOUT, MEM_TIMEOUT};
    for (int n = 0; n < 3; n++) begin
      Opcode = ops[n]; model(Opcode, 1'b0, 1'b0, ws[n]);
      while (exp_q.size() > 0) begin
        mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
        @(negedge CLK); o = cap(); total++;
        if (o !== e) begin bad++; $display("FAIL mem_wait op=%b waits=%0d got=%h exp=%h", Opcode, ws[n], o, e); end
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic test_sw_timeout();
    vec_t o, e;
    Opcode = SW; model(SW, 1'b0, 1'b0, MEM_TIMEOUT + 1);
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge CLK); o = cap(); total++;
      if (o !== e) begin bad++; $display("FAIL sw_timeout st=%0d got=%h exp=%h", e.st, o, e); end
      @(posedge CLK); #1;
    end
    Reset = 1'b1; #1;
    total++;
    if (State !== 4'd0 || mem_err !== 1'b0 || trap !== 1'b0) begin
      bad++; $display("FAIL timeout_reset got st=%0d me=%b trap=%b exp st=0 me=0 trap=0", State, mem_err, trap);
    end
    @(posedge CLK); #1;
    Reset = 1'b0; me_m = 1'b0;
  endtask

  task automatic test_jump_halt();
    vec_t o, e;
    logic [5:0] ops [4] = '{JAL, J, JR, HLT};
    for (int n = 0; n < 4; n++) begin
      Opcode = ops[n]; model(Opcode, 1'b0, 1'b0, 0);
      while (exp_q.size() > 0) begin
        mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
        @(negedge CLK); o = cap(); total++;
        if (o !== e) begin bad++; $display("FAIL jump_halt op=%b got=%h exp=%h", Opcode, o, e); end
        @(posedge CLK); #1;
      end
    end
    do_reset();
  endtask

  task automatic test_illegal();
    vec_t o, e;
    Opcode = ILL; model(ILL, 1'b0, 1'b0, 0);
    while (exp_q.size() > 0) begin
      mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge CLK); o = cap(); total++;
      if (o !== e) begin bad++; $display("FAIL illegal got=%h exp=%h", o, e); end
      @(posedge CLK); #1;
    end
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    vec_t o, e;
    Opcode = LW; model(LW, 1'b0, 1'b0, MEM_TIMEOUT + 1);
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
      @(negedge CLK); o = cap(); total++;
      if (o !== e) begin bad++; $display("FAIL mid_mem_pre got=%h exp=%h", o, e); end
      @(posedge CLK); #1;
    end
    exp_q.delete(); rdy_q.delete();
    #2 Reset = 1'b1; #1;
    total++;
    if (State !== 4'd0 || nRD !== 1'b1 || IRWre !== 1'b0 || mem_err !== 1'b0) begin
      bad++; $display("FAIL mid_mem_reset got st=%0d nRD=%b IRWre=%b me=%b exp st=0 nRD=1 IRWre=0 me=0", State, nRD, IRWre, mem_err);
    end
    me_m = 1'b0;
    @(posedge CLK); #1;
    Reset = 1'b0;
  endtask

  task automatic test_random();
    vec_t o, e;
    for (int n = 0; n < 80; n++) begin
      Opcode = legal[$urandom_range(0, 16)];
      zero = 1'($urandom); sign = 1'($urandom);
      model(Opcode, zero, sign, $urandom_range(0, MEM_TIMEOUT));
      while (exp_q.size() > 0) begin
        mem_ready = rdy_q.pop_front(); e = exp_q.pop_front();
        @(negedge CLK); o = cap(); total++;
        if (o !== e) begin bad++; $display("FAIL random n=%0d op=%b got=%h exp=%h", n, Opcode, o, e); end
        @(posedge CLK); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_mem_wait();
    test_sw_timeout();
    test_jump_halt();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
